// File: rtl/vt52_uart_fifo.sv
// VT52 serial port: TX/RX FIFOs, shared baud prescaler with oversampling,
// majority-vote RX bit recovery, break generation/detection and per-character status.
module vt52_uart_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    char_length,
  input  logic [1:0]                    stop_bits,
  input  logic [1:0]                    parity_mode,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_load,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  input  logic                          tx_break,
  output logic [7:0]                    rx_data,
  output logic [2:0]                    rx_status,
  output logic                          rx_valid,
  input  logic                          rx_read,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          overrun_error,
  output logic                          break_detect,
  output logic                          serial_out,
  input  logic                          serial_in
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2*OVERSAMPLE);
  localparam int RW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE-1);
  localparam logic [CW-1:0] STOP15_LAST = CW'(3*OVERSAMPLE/2-1);
  localparam logic [CW-1:0] STOP2_LAST = CW'(2*OVERSAMPLE-1);
  localparam logic [RW-1:0] S0     = RW'(OVERSAMPLE/2-1);
  localparam logic [RW-1:0] S1     = RW'(OVERSAMPLE/2);
  localparam logic [RW-1:0] S2     = RW'(OVERSAMPLE/2+1);
  localparam logic [RW-1:0] R_LAST = RW'(OVERSAMPLE-1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                         TX_PAR  = 3'd3, TX_STOP  = 3'd4;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
                         RX_PAR  = 3'd3, RX_STOP  = 3'd4, RX_WAIT = 3'd5;

  function automatic logic [7:0] len_mask(input logic [1:0] len);
    case (len)
      2'b00:   len_mask = 8'h1F;
      2'b01:   len_mask = 8'h3F;
      2'b10:   len_mask = 8'h7F;
      default: len_mask = 8'hFF;
    endcase
  endfunction

  // Prescaler: the divisor is re-sampled only at wrap so a period is never cut short.
  logic [DIV_W-1:0] pre_cnt, div_q;
  logic             tick;
  assign tick = (pre_cnt >= div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      div_q   <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      div_q   <= baud_div;
    end else begin
      pre_cnt <= pre_cnt + DIV_W'(1);
    end
  end

  // TX FIFO
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd;
  logic tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0] tx_head, tx_masked;

  assign tx_level  = tx_wr - tx_rd;
  assign tx_empty  = (tx_wr == tx_rd);
  assign tx_full   = (tx_level == FULL_LEVEL);
  assign tx_ready  = !tx_full;
  assign tx_push   = tx_load && !tx_full;
  assign tx_head   = tx_mem[tx_rd[AW-1:0]];
  assign tx_masked = tx_head & len_mask(char_length);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + (AW+1)'(1);
      if (tx_pop)  tx_rd <= tx_rd + (AW+1)'(1);
    end
  end

  // TX FSM
  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt, tx_stop_last;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_par_bit, tx_par_en, tx_line;
  logic [1:0]    tx_len, tx_stop;

  assign tx_pop  = (tx_state == TX_IDLE) && tick && !tx_empty && !tx_break;
  assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

  always_comb begin
    case (tx_stop)
      2'b00:   tx_stop_last = BIT_LAST;
      2'b01:   tx_stop_last = STOP15_LAST;
      default: tx_stop_last = STOP2_LAST;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_IDLE:  tx_line = !tx_break;
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      TX_PAR:   tx_line = tx_par_bit;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par_bit <= 1'b0;
      tx_par_en  <= 1'b0;
      tx_len     <= '0;
      tx_stop    <= '0;
      serial_out <= 1'b1;
    end else begin
      serial_out <= tx_line;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state   <= TX_START;
            tx_cnt     <= '0;
            tx_shift   <= tx_masked;
            tx_par_bit <= (^tx_masked) ^ (parity_mode == 2'b01);
            tx_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            tx_len     <= char_length;
            tx_stop    <= stop_bits;
          end
        end
        TX_START: if (tick) begin
          if (tx_cnt == BIT_LAST) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_idx   <= '0;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_DATA: if (tick) begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= tx_shift >> 1;
            if (tx_idx == {1'b0, tx_len} + 3'd4) tx_state <= tx_par_en ? TX_PAR : TX_STOP;
            else tx_idx <= tx_idx + 3'd1;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_PAR: if (tick) begin
          if (tx_cnt == BIT_LAST) begin
            tx_state <= TX_STOP;
            tx_cnt   <= '0;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_STOP: if (tick) begin
          if (tx_cnt == tx_stop_last) tx_state <= TX_IDLE;
          else tx_cnt <= tx_cnt + CW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX synchroniser; idles high so reset does not look like a start bit.
  logic [1:0] rx_sync;
  logic       rx_bit;
  assign rx_bit = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], serial_in};
  end

  // RX FSM
  logic [2:0]    rx_state;
  logic [RW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [1:0]    rx_samp, rx_len, rx_pmode;
  logic          rx_perr, rx_pbit, rx_pen, maj, stop_fe, stop_brk, rx_push;
  logic [10:0]   rx_entry;

  assign maj      = (rx_samp[0] & rx_samp[1]) | (rx_samp[0] & rx_bit) | (rx_samp[1] & rx_bit);
  assign rx_pen   = (rx_pmode == 2'b01) || (rx_pmode == 2'b10);
  assign stop_fe  = !maj;
  assign stop_brk = stop_fe && (rx_shift == 8'h00) && (!rx_pen || !rx_pbit);
  assign rx_push  = (rx_state == RX_STOP) && tick && (rx_cnt == S2);
  assign rx_entry = {stop_brk, rx_perr, stop_fe, rx_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_samp      <= '0;
      rx_len       <= '0;
      rx_pmode     <= '0;
      rx_perr      <= 1'b0;
      rx_pbit      <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          // The detecting tick is count 0, so the next tick is count 1.
          if (tick && !rx_bit) begin
            rx_state <= RX_START;
            rx_cnt   <= RW'(1);
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_pbit  <= 1'b0;
            rx_len   <= char_length;
            rx_pmode <= parity_mode;
          end
        end
        RX_WAIT: begin
          if (rx_bit) begin
            rx_state     <= RX_IDLE;
            break_detect <= 1'b0;
          end
        end
        default: if (tick) begin
          rx_cnt <= (rx_cnt == R_LAST) ? '0 : rx_cnt + RW'(1);
          if (rx_cnt == S0) rx_samp[0] <= rx_bit;
          if (rx_cnt == S1) rx_samp[1] <= rx_bit;
          case (rx_state)
            RX_START: begin
              if (rx_cnt == S2 && maj) rx_state <= RX_IDLE;
              else if (rx_cnt == R_LAST) begin
                rx_state <= RX_DATA;
                rx_idx   <= '0;
              end
            end
            RX_DATA: begin
              if (rx_cnt == S2) rx_shift[rx_idx] <= maj;
              if (rx_cnt == R_LAST) begin
                if (rx_idx == {1'b0, rx_len} + 3'd4) rx_state <= rx_pen ? RX_PAR : RX_STOP;
                else rx_idx <= rx_idx + 3'd1;
              end
            end
            RX_PAR: begin
              if (rx_cnt == S2) begin
                rx_pbit <= maj;
                rx_perr <= maj != ((^rx_shift) ^ (rx_pmode == 2'b01));
              end
              if (rx_cnt == R_LAST) rx_state <= RX_STOP;
            end
            RX_STOP: begin
              if (rx_cnt == S2) begin
                rx_state <= maj ? RX_IDLE : RX_WAIT;
                if (stop_brk) break_detect <= 1'b1;
              end
            end
            default: rx_state <= RX_IDLE;
          endcase
        end
      endcase
    end
  end

  // RX FIFO: a pop in the same clock frees the slot for a push into a full FIFO.
  logic [10:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr, rx_rd;
  logic rx_empty, rx_full, rx_pop, rx_wen;

  assign rx_level  = rx_wr - rx_rd;
  assign rx_empty  = (rx_wr == rx_rd);
  assign rx_full   = (rx_level == FULL_LEVEL);
  assign rx_valid  = !rx_empty;
  assign rx_pop    = rx_read && !rx_empty;
  assign rx_wen    = rx_push && (!rx_full || rx_pop);
  assign rx_data   = rx_mem[rx_rd[AW-1:0]][7:0];
  assign rx_status = rx_mem[rx_rd[AW-1:0]][10:8];

  always_ff @(posedge clk) begin
    if (rx_wen) rx_mem[rx_wr[AW-1:0]] <= rx_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr         <= '0;
      rx_rd         <= '0;
      overrun_error <= 1'b0;
    end else begin
      if (rx_wen) rx_wr <= rx_wr + (AW+1)'(1);
      if (rx_pop) rx_rd <= rx_rd + (AW+1)'(1);
      if (rx_push && rx_full && !rx_pop) overrun_error <= 1'b1;
      else if (rx_pop)                   overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vt52_uart_fifo.sv
// Directed bench for vt52_uart_fifo: TX waveform timing, loopback, bit-banged RX,
// overrun, break and tx_break, with an RX scoreboard queue.
module tb_vt52_uart_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    char_length, stop_bits, parity_mode;
  logic [15:0]   baud_div;
  logic [7:0]    tx_data;
  logic          tx_load, tx_ready, tx_busy, tx_break;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    rx_data;
  logic [2:0]    rx_status;
  logic          rx_valid, rx_read, overrun_error, break_detect;
  logic          serial_out, serial_in;
  logic          loop_en, drv_in;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb_q[$];
  logic [11:0] bits, model;

  assign serial_in = loop_en ? serial_out : drv_in;

  always #5 clk = ~clk;

  vt52_uart_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_length(char_length), .stop_bits(stop_bits), .parity_mode(parity_mode),
    .baud_div(baud_div),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_level(tx_level), .tx_break(tx_break),
    .rx_data(rx_data), .rx_status(rx_status), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_level(rx_level), .overrun_error(overrun_error), .break_detect(break_detect),
    .serial_out(serial_out), .serial_in(serial_in)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Expected line bits: start, data LSB first, optional parity, then stop (ones).
  function automatic logic [11:0] frameModel(input logic [7:0] d, input int nd, input int pm);
    logic [11:0] f;
    logic p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nd; i++) begin
      f[i+1] = d[i];
      p ^= d[i];
    end
    if (pm == 1) f[nd+1] = ~p;
    else if (pm == 2) f[nd+1] = p;
    return f;
  endfunction

  // Samples serial_out in the middle of each of nbits bit periods (64 clocks each).
  task automatic captureFrame(input int nbits, output logic [11:0] got);
    int n;
    n = 0;
    got = '1;
    while (serial_out !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (serial_out !== 1'b0) begin
      checkOutput("tx_start_seen", 32'(serial_out), 32'd0);
      return;
    end
    waitClocks(32);
    got[0] = serial_out;
    for (int k = 1; k < nbits; k++) begin
      waitClocks(64);
      got[k] = serial_out;
    end
  endtask

  task automatic compareFrame(input string tag, input int nbits);
    for (int k = 0; k < nbits; k++)
      checkOutput($sformatf("%s_bit%0d", tag, k), 32'(bits[k]), 32'(model[k]));
  endtask

  // Bit-bangs an 8N1 frame; with glitch set, each data bit gets a 1-clock
  // inversion at a different offset so at least one lands on a sample point.
  task automatic sendFrame(input logic [7:0] d, input bit glitch);
    drv_in = 1'b0;
    waitClocks(64);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 64; c++) begin
        drv_in = (glitch && c == 29 + k) ? ~d[k] : d[k];
        @(negedge clk);
      end
    end
    drv_in = 1'b1;
    waitClocks(64);
  endtask

  task automatic checkRx(input string tag);
    logic [10:0] want;
    int n;
    checkOutput({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() == 0) return;
    want = sb_q.pop_front();
    n = 0;
    while (!rx_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(rx_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(rx_data), 32'(want[7:0]));
    checkOutput({tag, "_status"}, 32'(rx_status), 32'(want[10:8]));
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0; tx_break = 1'b0; rx_read = 1'b0;
    loop_en = 1'b0; drv_in = 1'b1;
    char_length = 2'b11; stop_bits = 2'b00; parity_mode = 2'b00;
    baud_div = 16'd3;
    waitClocks(5);
    checkOutput("rst_serial_out", 32'(serial_out), 32'd1);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_tx_level", 32'(tx_level), 32'd0);
    checkOutput("rst_rx_level", 32'(rx_level), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_error), 32'd0);
    checkOutput("rst_break_detect", 32'(break_detect), 32'd0);
    rst_n = 1'b1;
    waitClocks(5);

    $display("[TB] 8N1 transmit 0x55");
    applyStimulus(8'h55);
    captureFrame(10, bits);
    model = frameModel(8'h55, 8, 0);
    compareFrame("tx55", 10);
    waitClocks(24);
    checkOutput("tx55_busy_in_stop", 32'(tx_busy), 32'd1);
    waitClocks(12);
    checkOutput("tx55_busy_after_stop", 32'(tx_busy), 32'd0);
    checkOutput("tx55_idle_line", 32'(serial_out), 32'd1);

    $display("[TB] loopback 7E2 0x41");
    char_length = 2'b10; stop_bits = 2'b10; parity_mode = 2'b10;
    loop_en = 1'b1;
    waitClocks(10);
    sb_q.push_back({3'b000, 8'h41});
    applyStimulus(8'h41);
    captureFrame(10, bits);
    model = frameModel(8'h41, 7, 2);
    compareFrame("lb7e2", 10);
    waitClocks(88);
    checkOutput("lb7e2_busy_in_stop", 32'(tx_busy), 32'd1);
    waitClocks(12);
    checkOutput("lb7e2_busy_after_stop", 32'(tx_busy), 32'd0);
    checkRx("lb7e2_rx");

    $display("[TB] loopback 7O1.5 0x41");
    stop_bits = 2'b01; parity_mode = 2'b01;
    waitClocks(10);
    sb_q.push_back({3'b000, 8'h41});
    applyStimulus(8'h41);
    captureFrame(10, bits);
    model = frameModel(8'h41, 7, 1);
    compareFrame("lb7o15", 10);
    waitClocks(56);
    checkOutput("lb7o15_busy_in_stop", 32'(tx_busy), 32'd1);
    waitClocks(12);
    checkOutput("lb7o15_busy_after_stop", 32'(tx_busy), 32'd0);
    checkRx("lb7o15_rx");

    $display("[TB] false start and glitched frame");
    loop_en = 1'b0;
    char_length = 2'b11; stop_bits = 2'b00; parity_mode = 2'b00;
    waitClocks(64);
    drv_in = 1'b0;
    waitClocks(20);
    drv_in = 1'b1;
    waitClocks(700);
    checkOutput("false_start_valid", 32'(rx_valid), 32'd0);
    checkOutput("false_start_level", 32'(rx_level), 32'd0);
    sb_q.push_back({3'b000, 8'hA5});
    sendFrame(8'hA5, 1'b1);
    checkRx("glitch_rx");

    $display("[TB] RX overrun");
    waitClocks(64);
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) sb_q.push_back({3'b000, 8'(8'h31 + i)});
      sendFrame(8'(8'h31 + i), 1'b0);
    end
    waitClocks(8);
    checkOutput("ovr_level_full", 32'(rx_level), 32'(DEPTH));
    checkOutput("ovr_flag_set", 32'(overrun_error), 32'd1);
    checkRx("ovr_head0");
    checkOutput("ovr_flag_cleared", 32'(overrun_error), 32'd0);
    checkOutput("ovr_level_after_pop", 32'(rx_level), 32'(DEPTH - 1));
    for (int i = 1; i < DEPTH; i++) checkRx($sformatf("ovr_head%0d", i));

    $display("[TB] line break");
    waitClocks(64);
    sb_q.push_back({3'b101, 8'h00});
    drv_in = 1'b0;
    waitClocks(700);
    checkOutput("brk_detect_set", 32'(break_detect), 32'd1);
    checkOutput("brk_level_one", 32'(rx_level), 32'd1);
    waitClocks(68);
    drv_in = 1'b1;
    waitClocks(10);
    checkOutput("brk_detect_cleared", 32'(break_detect), 32'd0);
    checkOutput("brk_single_entry", 32'(rx_level), 32'd1);
    checkRx("brk_rx");
    waitClocks(64);
    sb_q.push_back({3'b000, 8'h5A});
    sendFrame(8'h5A, 1'b0);
    checkRx("after_brk_rx");

    $display("[TB] tx_break with full TX FIFO");
    tx_break = 1'b1;
    waitClocks(8);
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) sb_q.push_back({3'b000, 8'(8'h11 + i)});
      applyStimulus(8'(8'h11 + i));
    end
    waitClocks(20);
    checkOutput("txbrk_level", 32'(tx_level), 32'(DEPTH));
    checkOutput("txbrk_ready", 32'(tx_ready), 32'd0);
    checkOutput("txbrk_line_low", 32'(serial_out), 32'd0);
    checkOutput("txbrk_busy", 32'(tx_busy), 32'd1);
    loop_en = 1'b1;
    tx_break = 1'b0;
    waitClocks(4 * 640 + 100);
    checkOutput("txbrk_drained", 32'(tx_level), 32'd0);
    checkOutput("txbrk_idle", 32'(tx_busy), 32'd0);
    checkOutput("txbrk_rx_level", 32'(rx_level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) checkRx($sformatf("txbrk_rx%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vt52_uart_fifo.md
Name: vt52_uart_fifo

Overview:
Next-generation serial port for the VT52 terminal core. It adds parametrised RX and TX FIFOs, a shared fractional-free baud prescaler with N-times oversampling, 3-sample majority-vote bit recovery, and correct 1.5-stop-bit timing. It also adds per-character error status, break generation/detection, and per-frame latching of the line configuration. It sits between the host-interface/keyboard logic and the external TX/RX pins.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2
OVERSAMPLE, 16, prescaler ticks per bit; even, at least 8
DIV_W, 16, width of baud_div

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
char_length  in  2  00=5, 01=6, 10=7, 11=8 data bits
stop_bits  in  2  00=1, 01=1.5, 10=2 (11 treated as 2)
parity_mode  in  2  00=none, 01=odd, 10=even (11 treated as none)
baud_div  in  DIV_W  tick every baud_div+1 clocks
tx_data  in  8  byte to queue
tx_load  in  1  push tx_data when tx_ready
tx_ready  out  1  TX FIFO not full
tx_busy  out  1  TX FSM not idle, or TX FIFO non-empty
tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
tx_break  in  1  force line low
rx_data  out  8  head of RX FIFO (first-word fall-through)
rx_status  out  3  head entry {break, parity_err, framing_err}
rx_valid  out  1  RX FIFO not empty
rx_read  in  1  pop head when rx_valid
rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
overrun_error  out  1  sticky: character dropped, RX FIFO full
break_detect  out  1  line-break level indicator
serial_out  out  1  TX line
serial_in  in  1  RX line (asynchronous)

Behaviour:
- Reset values: serial_out=1, tx_ready=1, tx_busy=0, levels=0, rx_valid=0, overrun_error=0, break_detect=0. rx_data/rx_status are meaningful only while rx_valid=1. All FSMs go IDLE and all FIFO pointers clear. Reset mid-frame aborts the frame with no push.
- Prescaler: counter 0..baud_div, wraps and emits a 1-clock tick at baud_div. It is free-running; a changed baud_div takes effect at the next wrap. baud_div=0 gives a tick every clock.
- Frame config (length, stop, parity) is latched at the start of each TX and each RX frame. Mid-frame changes are ignored.
- serial_in passes through a 2-flop synchroniser; all RX decisions use the synchronised bit.
- TX FIFO: push on tx_load&&tx_ready. tx_load while full is dropped silently.
- TX FSM: IDLE→START→DATA (LSB first)→[PARITY]→STOP→IDLE. In IDLE, on a tick with FIFO non-empty and tx_break=0: pop and enter START.
  - Each bit lasts OVERSAMPLE ticks.
  - STOP lasts OVERSAMPLE, 3*OVERSAMPLE/2 or 2*OVERSAMPLE ticks.
  - Parity is the XOR of data bits; even parity sends that XOR, odd parity sends its inverse.
- tx_break: a frame in progress completes first. Thereafter serial_out=0 and no pops occur while tx_break=1. Normal operation resumes in IDLE, with the line high, after deassertion.
- RX FSM: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A per-bit tick counter runs 0..OVERSAMPLE-1.
  - IDLE→START on the first tick with the synced bit low.
  - Sample points are counts OVERSAMPLE/2-1, /2 and /2+1; the bit value is the majority of the three. The bit is resolved at /2+1.
  - START with majority high → IDLE (false start, no push).
  - DATA: shift in char_length+5 bits LSB first, zero-extended to 8 bits.
  - PARITY: parity_err is set if the received bit differs from the expected value.
  - STOP: resolve the stop bit and push {break, parity_err, framing_err, data} at once; no wait for the stop-bit end.
  - framing_err = stop bit 0.
  - break = framing_err, all data bits 0, and parity bit 0 (when parity is enabled).
  - After STOP: framing_err=0 → IDLE; otherwise → WAIT_HIGH, which returns to IDLE once the synced bit is 1.
- break_detect is set with a break push and cleared when WAIT_HIGH sees the line high. At most one entry is pushed per break.
- RX FIFO full on push: the new character is dropped, FIFO contents are unchanged, and overrun_error=1. overrun_error clears on the next rx_read pop.
- Push and pop in the same clock when full: the pop is applied first and the push succeeds, with no overrun.
- rx_read while empty is ignored.
- Levels update the clock after a push or pop. A simultaneous push and pop leaves the level unchanged.

Test Plan:
- baud_div=3, OVERSAMPLE=16 (bit=64 clks), 8N1, load 0x55 → serial_out low 64 clks, then 1,0,1,0,1,0,1,0 at 64 clks each, then high 64 clks; tx_busy falls after the stop bit.
- Loopback at 7E2 with 0x41 → parity bit 0, stop high 128 clks, rx_data=0x41, rx_status=000. Repeat at 7O1.5 → parity bit 1, stop 96 clks, status 000.
- serial_in low pulse of 20 clks at baud_div=3 → false start, rx_valid stays 0. Single-clk glitch mid data bit → majority vote gives the correct byte.
- FIFO_DEPTH=4: receive 5 chars 0x31..0x35 without reading → rx_level=4, overrun_error=1, head=0x31. One rx_read → head=0x32, overrun_error=0.
- serial_in held low 12 bit times, then high → exactly one entry, data 0x00, status 101 (parity none). break_detect=1 until the line returns high; the next char is received normally.
- tx_break=1 and FIFO_DEPTH=4: 5 consecutive tx_loads → tx_level=4, tx_ready=0, 5th dropped, serial_out=0. Release → 4 frames sent in order.
